program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Sits between a synchronous instruction ROM and the processor core's control unit.
- Fetches 9-bit instruction words (IIIXXXYYY) and presents them on DIN with a one-cycle RUN pulse, then waits for the core's DONE.
- For mvi it pre-fetches the immediate word and drives it on DIN during execution.
- Provides a program counter, single-step mode, an instruction count and a sticky error trap.

Parameters:
- ADDR_W, 5: ROM address width; PC wraps modulo 2^ADDR_W.
- START_ADDR, 0: PC value after reset.
- TIMEOUT, 7: maximum cycles spent in EXEC waiting for DONE before trapping.

Ports:
- CLOCK  in  1  single clock, all state updates on its rising edge.
- RESETN  in  1  synchronous, active-low reset.
- ENABLE  in  1  level; high allows fetching of new instructions.
- STEP  in  1  level; high = single-step mode (return to IDLE after each instruction).
- MEM_ADDR  out  ADDR_W  ROM address; combinationally equal to PC.
- MEM_RDATA  in  9  ROM data, valid one cycle after MEM_ADDR is presented.
- DIN  out  9  registered data bus to the processor.
- RUN  out  1  one-cycle pulse; the processor loads its IR from DIN.
- DONE  in  1  processor instruction complete.
- PC  out  ADDR_W  current program counter (debug).
- BUSY  out  1  high in every state except IDLE and TRAP.
- ERROR  out  1  sticky; illegal opcode or DONE timeout.
- INSTR_COUNT  out  16  number of completed instructions, saturating.

Behaviour:
- Reset, when RESETN=0 at a clock edge, regardless of state:
  - state=IDLE, PC=START_ADDR, DIN=0, RUN=0, BUSY=0, ERROR=0, INSTR_COUNT=0.
  - Reset aborts any in-flight instruction and clears TRAP.
- Opcodes: 001 mv, 010 mvi, 011 add, 100 sub. Any other value is illegal.
- State machine:
  - IDLE: if ENABLE=1 -> FETCH.
  - FETCH: MEM_ADDR=PC -> LATCH.
  - LATCH:
    - ir_hold<=MEM_RDATA; PC<=PC+1 (wraps to 0).
    - If opcode is illegal -> TRAP.
    - Else if opcode is mvi -> IMM_FETCH.
    - Else -> ISSUE.
  - IMM_FETCH: MEM_ADDR=PC -> IMM_LATCH.
  - IMM_LATCH: imm_hold<=MEM_RDATA; PC<=PC+1 (wraps) -> ISSUE.
  - ISSUE: DIN=ir_hold, RUN=1 for exactly this cycle; clear wait counter -> EXEC.
  - EXEC:
    - RUN=0. DIN=imm_hold for mvi, otherwise ir_hold.
    - Increment wait counter each cycle.
    - On DONE=1: INSTR_COUNT+1, saturating at 16'hFFFF. Then:
      - STEP=1 -> IDLE.
      - else ENABLE=1 -> FETCH.
      - else -> IDLE.
    - If the wait counter reaches TIMEOUT with no DONE -> TRAP.
  - TRAP: ERROR=1, BUSY=0, RUN=0; stays in TRAP until reset.
- Latency:
  - ENABLE sampled high in IDLE at edge n: RUN is high during cycle n+3 for non-mvi, n+5 for mvi.
  - Back-to-back instructions: FETCH follows the DONE cycle immediately.
- DONE is sampled only in EXEC; DONE in any other state is ignored.
- ENABLE deasserted mid-instruction: the instruction completes, then the block goes to IDLE. PC is not rewound.
- STEP rising during EXEC takes effect at that instruction's DONE.
- PC wrap: an mvi at address 2^ADDR_W-1 fetches its immediate from address 0.
- DIN holds its last value in IDLE and TRAP.

Decomposition:
- Shared package:
  - opcode constants OP_MV=3'b001, OP_MVI=3'b010, OP_ADD=3'b011, OP_SUB=3'b100.
  - WORD_W=9.
  - state encoding for IDLE/FETCH/LATCH/IMM_FETCH/IMM_LATCH/ISSUE/EXEC/TRAP.
  - These are shared with the processor control unit and the bench.
- One natural sub-module: seq_pc_counter, a loadable, wrap-around ADDR_W counter with increment enable and synchronous active-low reset to START_ADDR.
- FSM, hold registers and the instruction counter stay in the top module.

Test Plan:
- Reset then ENABLE=1, ROM[0]=0x0C1 (add R0,R1), DONE returned 3 cycles after RUN:
  - RUN high exactly one cycle, 3 cycles after ENABLE, with DIN=0x0C1.
  - INSTR_COUNT=1, PC=1, next FETCH begins.
- ROM[0]=0x080 (mvi R0), ROM[1]=0x005:
  - RUN at cycle n+5 with DIN=0x080; the cycle after, DIN=0x005.
  - After DONE, PC=2.
- ROM[2]=0x000 (illegal):
  - ERROR=1 and BUSY=0 after the LATCH cycle; RUN is never asserted.
  - Remains in TRAP until RESETN=0; reset clears ERROR and sets PC=0.
- ROM[0]=0x040 (mv), DONE withheld:
  - ERROR=1 after TIMEOUT=7 EXEC cycles.
  - A DONE pulsed during FETCH is ignored.
- STEP=1, ENABLE=1, three mv instructions:
  - One instruction per return to IDLE; INSTR_COUNT goes 1,2,3.
  - ENABLE dropped during EXEC: current instruction finishes, block goes to IDLE, PC=next address.
- ADDR_W=2, mvi at address 3, immediate at address 0:
  - PC wraps to 0, immediate taken from ROM[0], final PC=1.
  - RESETN=0 asserted mid-EXEC: next cycle state=IDLE, RUN=0, PC=0.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer, the core control unit
// and the bench: word width, opcodes and sequencer state encoding.
package program_sequencer_pkg;

    localparam int WORD_W = 9;

    localparam logic [2:0] OP_MV  = 3'b001;
    localparam logic [2:0] OP_MVI = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_IMM_FETCH,
        ST_IMM_LATCH,
        ST_ISSUE,
        ST_EXEC,
        ST_TRAP
    } seq_state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_MV) || (op == OP_MVI) ||
               (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/program_sequencer_pc_counter.sv
// Loadable wrap-around program counter with increment enable.
module seq_pc_counter #(
    parameter int                ADDR_W     = 5,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= START_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/program_sequencer.sv
// Fetches instruction words from a synchronous ROM and issues them to
// the core with a RUN pulse, then waits for DONE (with timeout trap).
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 7
) (
    input  logic              CLOCK,
    input  logic              RESETN,
    input  logic              ENABLE,
    input  logic              STEP,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [WORD_W-1:0] MEM_RDATA,
    output logic [WORD_W-1:0] DIN,
    output logic              RUN,
    input  logic              DONE,
    output logic [ADDR_W-1:0] PC,
    output logic              BUSY,
    output logic              ERROR,
    output logic [15:0]       INSTR_COUNT
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    seq_state_t        state_q;
    logic [WORD_W-1:0] ir_q;
    logic [WORD_W-1:0] imm_q;
    logic [WORD_W-1:0] din_q;
    logic              run_q;
    logic              err_q;
    logic [15:0]       cnt_q;
    logic [WAIT_W-1:0] wait_q;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    assign pc_inc = (state_q == ST_LATCH) || (state_q == ST_IMM_LATCH);

    seq_pc_counter #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(ADDR_W'(START_ADDR))
    ) u_pc (
        .clk_i     (CLOCK),
        .rst_ni    (RESETN),
        .load_i    (1'b0),
        .load_val_i('0),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            run_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ENABLE) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    ir_q <= MEM_RDATA;
                    if (!op_legal(MEM_RDATA[8:6])) begin
                        state_q <= ST_TRAP;
                        err_q   <= 1'b1;
                    end else if (MEM_RDATA[8:6] == OP_MVI) begin
                        state_q <= ST_IMM_FETCH;
                    end else begin
                        // RUN and DIN are registered, so load them on entry to ISSUE
                        state_q <= ST_ISSUE;
                        din_q   <= MEM_RDATA;
                        run_q   <= 1'b1;
                    end
                end
                ST_IMM_FETCH: begin
                    state_q <= ST_IMM_LATCH;
                end
                ST_IMM_LATCH: begin
                    imm_q   <= MEM_RDATA;
                    din_q   <= ir_q;
                    run_q   <= 1'b1;
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    wait_q  <= '0;
                    din_q   <= (ir_q[8:6] == OP_MVI) ? imm_q : ir_q;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (DONE) begin
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                        if (STEP) begin
                            state_q <= ST_IDLE;
                        end else if (ENABLE) begin
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q <= ST_TRAP;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_TRAP: begin
                    err_q <= 1'b1;
                end
            endcase
        end
    end

    assign MEM_ADDR    = pc;
    assign PC          = pc;
    assign DIN         = din_q;
    assign RUN         = run_q;
    assign ERROR       = err_q;
    assign INSTR_COUNT = cnt_q;
    assign BUSY        = (state_q != ST_IDLE) && (state_q != ST_TRAP);

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: directed ROM programs, expected RUN/DIN pushed on
// issue and checked by a monitor on every RUN pulse.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rstn = 1'b0;

    // DUT 0: ADDR_W=5
    logic en0 = 1'b0, step0 = 1'b0;
    logic [4:0] maddr0, pc0;
    logic [8:0] rd0 = '0, din0;
    logic run0, done0, busy0, err0;
    logic [15:0] cnt0;
    logic [8:0] rom0 [32];

    // DUT 1: ADDR_W=2 for wrap tests
    logic en1 = 1'b0;
    logic [1:0] maddr1, pc1;
    logic [8:0] rd1 = '0, din1;
    logic run1, done1, busy1, err1;
    logic [15:0] cnt1;
    logic [8:0] rom1 [4];

    always @(posedge clk) rd0 <= rom0[maddr0];
    always @(posedge clk) rd1 <= rom1[maddr1];

    program_sequencer #(.ADDR_W(5), .START_ADDR(0), .TIMEOUT(7)) u0 (
        .CLOCK(clk), .RESETN(rstn), .ENABLE(en0), .STEP(step0),
        .MEM_ADDR(maddr0), .MEM_RDATA(rd0), .DIN(din0), .RUN(run0),
        .DONE(done0), .PC(pc0), .BUSY(busy0), .ERROR(err0),
        .INSTR_COUNT(cnt0)
    );

    program_sequencer #(.ADDR_W(2), .START_ADDR(0), .TIMEOUT(7)) u1 (
        .CLOCK(clk), .RESETN(rstn), .ENABLE(en1), .STEP(1'b0),
        .MEM_ADDR(maddr1), .MEM_RDATA(rd1), .DIN(din1), .RUN(run1),
        .DONE(done1), .PC(pc1), .BUSY(busy1), .ERROR(err1),
        .INSTR_COUNT(cnt1)
    );

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        ntot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     nm, act, exp, cyc);
        else
            npass++;
    endtask

    // DONE responders: pulse DONE a fixed delay after each RUN
    bit done_auto = 1'b1;
    int done_delay = 3;
    int d0cnt = 0;
    logic done_a0 = 1'b0, done_f = 1'b0;
    assign done0 = done_a0 | done_f;

    always @(negedge clk) begin
        done_a0 = 1'b0;
        if (run0 && done_auto) d0cnt = done_delay;
        else if (d0cnt > 0) begin
            d0cnt--;
            if (d0cnt == 0) done_a0 = 1'b1;
        end
    end

    int d1cnt = 0;
    logic done_a1 = 1'b0;
    assign done1 = done_a1;

    always @(negedge clk) begin
        done_a1 = 1'b0;
        if (run1) d1cnt = 2;
        else if (d1cnt > 0) begin
            d1cnt--;
            if (d1cnt == 0) done_a1 = 1'b1;
        end
    end

    // Scoreboard for DUT 0
    typedef struct {
        logic [8:0] din;
        logic [8:0] imm;
        bit         has_imm;
        int         ecyc;
    } exp_t;

    exp_t sbq[$];
    bit imm_pend = 1'b0, pulse_pend = 1'b0;
    logic [8:0] imm_exp = '0;

    task automatic push(input logic [8:0] d, input bit hi,
                        input logic [8:0] im, input int ec);
        exp_t e;
        e.din = d; e.has_imm = hi; e.imm = im; e.ecyc = ec;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        bit was_pend;
        exp_t e;
        was_pend = imm_pend | pulse_pend;
        if (imm_pend) check("exec_din_imm", din0, imm_exp);
        if (was_pend) check("run_one_cycle", run0, 0);
        imm_pend = 1'b0;
        pulse_pend = 1'b0;
        if (run0 && !was_pend) begin
            check("run_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("run_din", din0, e.din);
                if (e.ecyc >= 0) check("run_cycle", cyc, e.ecyc);
                pulse_pend = 1'b1;
                if (e.has_imm) begin
                    imm_pend = 1'b1;
                    imm_exp = e.imm;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        en0 = 0; step0 = 0; en1 = 0; done_f = 0;
        rstn = 0;
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic wait_idle0(input string nm);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy0) begin ok = 1; break; end
        end
        check(nm, ok, 1);
    endtask

    task automatic wait_cnt0(input int n, input string nm);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cnt0 == 16'(n)) begin ok = 1; break; end
        end
        check(nm, ok, 1);
    endtask

    task automatic wait_run1(input string nm);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (run1) begin ok = 1; break; end
        end
        check(nm, ok, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom0[i] = 9'h000;
        rom1[0] = 9'h040; rom1[1] = 9'h0C1;
        rom1[2] = 9'h048; rom1[3] = 9'h080;

        // Test 1: add, back-to-back fetch
        rom0[0] = 9'h0C1; rom0[1] = 9'h0D3;
        done_auto = 1; done_delay = 3;
        do_reset();
        check("rst_pc", pc0, 0);
        check("rst_din", din0, 0);
        check("rst_run", run0, 0);
        check("rst_busy", busy0, 0);
        check("rst_err", err0, 0);
        check("rst_cnt", cnt0, 0);
        @(negedge clk);
        // ENABLE sampled at next edge n; ISSUE occupies the 3rd cycle
        push(9'h0C1, 0, 9'h0, cyc + 3);
        en0 = 1;
        wait_cnt0(1, "t1_done1");
        check("t1_pc", pc0, 1);
        check("t1_fetch_busy", busy0, 1);
        check("t1_maddr", maddr0, 1);
        push(9'h0D3, 0, 9'h0, -1);
        en0 = 0;
        wait_idle0("t1_idle");
        check("t1_cnt2", cnt0, 2);
        check("t1_pc2", pc0, 2);

        // Test 2: mvi then illegal opcode
        rom0[0] = 9'h080; rom0[1] = 9'h005; rom0[2] = 9'h000;
        do_reset();
        @(negedge clk);
        push(9'h080, 1, 9'h005, cyc + 5);
        en0 = 1;
        @(negedge clk);
        en0 = 0;
        wait_idle0("t2_idle");
        check("t2_pc", pc0, 2);
        check("t2_cnt", cnt0, 1);
        en0 = 1;
        repeat (3) @(negedge clk);
        check("t2_trap_err", err0, 1);
        check("t2_trap_busy", busy0, 0);
        check("t2_trap_pc", pc0, 3);
        repeat (5) @(negedge clk);
        check("t2_trap_stay", err0, 1);
        check("t2_trap_cnt", cnt0, 1);
        do_reset();
        check("t2_rst_err", err0, 0);
        check("t2_rst_pc", pc0, 0);

        // Test 3: DONE withheld -> timeout; DONE in FETCH ignored
        rom0[0] = 9'h040;
        done_auto = 0;
        @(negedge clk);
        push(9'h040, 0, 9'h0, cyc + 3);
        en0 = 1;
        @(negedge clk);
        en0 = 0; done_f = 1;
        @(negedge clk);
        done_f = 0;
        repeat (8) @(negedge clk);
        check("t3_pre_err", err0, 0);
        check("t3_pre_busy", busy0, 1);
        @(negedge clk);
        check("t3_to_err", err0, 1);
        check("t3_to_busy", busy0, 0);
        check("t3_to_cnt", cnt0, 0);

        // Test 4: single step, then ENABLE dropped mid-EXEC
        rom0[0] = 9'h040; rom0[1] = 9'h048;
        rom0[2] = 9'h050; rom0[3] = 9'h0C1;
        done_auto = 1; done_delay = 2;
        do_reset();
        push(9'h040, 0, 9'h0, -1);
        push(9'h048, 0, 9'h0, -1);
        push(9'h050, 0, 9'h0, -1);
        step0 = 1; en0 = 1;
        for (int i = 1; i <= 3; i++) begin
            wait_cnt0(i, "t4_step_cnt");
            check("t4_step_idle", busy0, 0);
            check("t4_step_pc", pc0, i);
        end
        en0 = 0; step0 = 0;
        @(negedge clk);
        push(9'h0C1, 0, 9'h0, cyc + 3);
        en0 = 1;
        repeat (4) @(negedge clk);
        en0 = 0;
        wait_idle0("t4_idle");
        check("t4_pc", pc0, 4);
        check("t4_cnt", cnt0, 4);

        // Test 5: ADDR_W=2, mvi at address 3 takes immediate from 0
        do_reset();
        en1 = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cnt1 == 16'd3) break;
        end
        check("t5_cnt3", cnt1, 3);
        check("t5_pc3", pc1, 3);
        wait_run1("t5_run");
        check("t5_run_din", din1, 9'h080);
        check("t5_pc_wrap", pc1, 1);
        en1 = 0;
        @(negedge clk);
        check("t5_imm", din1, 9'h040);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy1) break;
        end
        check("t5_idle", busy1, 0);
        check("t5_pc_final", pc1, 1);
        check("t5_cnt4", cnt1, 4);
        en1 = 1;
        wait_run1("t5_run2");
        @(negedge clk);
        en1 = 0; rstn = 0;
        @(negedge clk);
        check("t5_rst_busy", busy1, 0);
        check("t5_rst_run", run1, 0);
        check("t5_rst_pc", pc1, 0);
        check("t5_rst_cnt", cnt1, 0);
        rstn = 1;
        repeat (2) @(negedge clk);

        check("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
